vga_pixel_fetch: RTL

- Pixel-pipeline stage directly downstream of the 1024x768 VGA timing generator.
- Consumes the generator's HC/VC/EN/HS/VS and issues framebuffer reads to an external synchronous block RAM that stores a 4-bit colour index per pixel.
- Maps each index through a writable 16-entry palette and drives 12-bit RGB plus HS/VS, delayed so all outputs are mutually aligned.
- Also produces a frame-start pulse and a frame counter for game logic (blink, animation).

---
 rtl/vga_pixel_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch, palette lookup and sync alignment behind the 1024x768 VGA timing generator.
// Define VGA_PIXEL_BORDER_EN to force a white frame on the edge pixels of the active area.
module vga_pixel_fetch #(
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned FB_AW       = 18,
    parameter int unsigned RAM_LAT     = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [11:0]      HC,
    input  logic [11:0]      VC,
    input  logic             EN,
    input  logic             HS_IN,
    input  logic             VS_IN,
    output logic [FB_AW-1:0] FB_ADDR,
    input  logic [3:0]       FB_DATA,
    input  logic             PAL_WE,
    input  logic [3:0]       PAL_ADDR,
    input  logic [11:0]      PAL_DATA,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             FRAME_START,
    output logic [7:0]       FRAME_CNT
);
    localparam int unsigned L = RAM_LAT + 2;

    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [L-1:0]     en_q, en_d, hs_q, hs_d, vs_q, vs_d;
    logic [11:0]      pal_q [16];
    logic [11:0]      pal_d [16];
    logic [11:0]      rgb_q, rgb_d;
    logic             vs_prev_q, vs_prev_d, fs_q, fs_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             unused_ok;

`ifdef VGA_PIXEL_BORDER_EN
    // HC/VC only need to line up with the palette stage, one short of the sync taps.
    logic [11:0] hc_q [L-1];
    logic [11:0] hc_d [L-1];
    logic [11:0] vc_q [L-1];
    logic [11:0] vc_d [L-1];
`endif

    assign unused_ok = ^{HC, VC, en_q[L-1]};

    always_comb begin
        fb_addr_d = fb_addr_q;
        if (EN) begin
            fb_addr_d = FB_AW'({VC[9:SCALE_SHIFT], HC[9:SCALE_SHIFT]});
        end

        en_d = {en_q[L-2:0], EN};
        hs_d = {hs_q[L-2:0], HS_IN};
        vs_d = {vs_q[L-2:0], VS_IN};

        pal_d = pal_q;
        if (PAL_WE) begin
            pal_d[PAL_ADDR] = PAL_DATA;
        end

        // Lookup reads the pre-write palette, so a same-cycle write shows the old entry.
        rgb_d = 12'h000;
        if (en_q[L-2]) begin
            rgb_d = pal_q[FB_DATA];
        end

`ifdef VGA_PIXEL_BORDER_EN
        hc_d[0] = HC;
        vc_d[0] = VC;
        for (int k = 1; k < int'(L) - 1; k++) begin
            hc_d[k] = hc_q[k-1];
            vc_d[k] = vc_q[k-1];
        end
        if (en_q[L-2] && (hc_q[L-2] == 12'd0 || hc_q[L-2] == 12'd1023 ||
                          vc_q[L-2] == 12'd0 || vc_q[L-2] == 12'd767)) begin
            rgb_d = 12'hFFF;
        end
`endif

        vs_prev_d = vs_q[L-1];
        fs_d      = vs_prev_q & ~vs_q[L-1];
        cnt_d     = cnt_q + 8'(fs_d);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fb_addr_q <= '0;
            en_q      <= '0;
            hs_q      <= '1;
            vs_q      <= '1;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= {3{4'(i)}};
            end
            rgb_q     <= 12'h000;
            vs_prev_q <= 1'b1;
            fs_q      <= 1'b0;
            cnt_q     <= 8'h00;
`ifdef VGA_PIXEL_BORDER_EN
            for (int k = 0; k < int'(L) - 1; k++) begin
                hc_q[k] <= 12'h000;
                vc_q[k] <= 12'h000;
            end
`endif
        end else begin
            fb_addr_q <= fb_addr_d;
            en_q      <= en_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            pal_q     <= pal_d;
            rgb_q     <= rgb_d;
            vs_prev_q <= vs_prev_d;
            fs_q      <= fs_d;
            cnt_q     <= cnt_d;
`ifdef VGA_PIXEL_BORDER_EN
            hc_q      <= hc_d;
            vc_q      <= vc_d;
`endif
        end
    end

    assign FB_ADDR              = fb_addr_q;
    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_HS               = hs_q[L-1];
    assign VGA_VS               = vs_q[L-1];
    assign FRAME_START          = fs_q;
    assign FRAME_CNT            = cnt_q;

endmodule
